// File: rtl/synapse_arbiter.sv
// synapse_arbiter: round-robin arbiter that accumulates synaptic weights over a
// timestep of TICK_LEN cycles and issues the saturated sum as I_syn for one cycle.
// Optional refractory behaviour (spike_pend, REFRAC state, drop_cnt) is compiled
// in when the macro SYNAPSE_REFRACTORY_EN is defined; the default build omits it.
module synapse_arbiter #(
  parameter int N_REQ      = 4,
  parameter int W          = 8,
  parameter int TICK_LEN   = 16,
  parameter int REFRAC_LEN = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] weight,
  input  logic               spike_in,
  output logic [N_REQ-1:0]   ack,
  output logic [W-1:0]       i_syn,
  output logic               i_syn_valid,
  output logic               sat_flag,
  output logic [7:0]         drop_cnt,
  output logic               busy
);

  localparam int              PTR_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);
  localparam logic [7:0]      TICK_LAST = 8'(TICK_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_ISSUE  = 2'd2,
    S_REFRAC = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [W-1:0]     acc_q, acc_d;
  logic             sat_pend_q, sat_pend_d;
  logic [7:0]       tick_q, tick_d;
  logic [W-1:0]     i_syn_q, i_syn_d;
  logic             sat_flag_q, sat_flag_d;

  logic             gnt_found;
  logic [PTR_W-1:0] gnt_idx;
  logic [N_REQ-1:0] gnt_oh;
  logic [W-1:0]     gnt_w;
  logic             grant_en;
  logic             gnt;
  logic [W:0]       sum_sat;

`ifdef SYNAPSE_REFRACTORY_EN
  localparam logic [7:0] REFRAC_LAST = 8'(REFRAC_LEN - 1);

  logic       spike_pend_q, spike_pend_d;
  logic [7:0] refrac_q, refrac_d;
  logic [7:0] drop_q, drop_d;

  // Counter increment that sticks at its maximum value.
  function automatic logic [7:0] sat_inc8(input logic [7:0] c);
    sat_inc8 = (c == 8'hFF) ? c : c + 8'd1;
  endfunction
`endif

  // Unsigned add clamped to 2^W-1; MSB of the result flags that clamping occurred.
  function automatic logic [W:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum[W]) sat_add = {1'b1, {W{1'b1}}};
    else        sat_add = sum;
  endfunction

  // Round-robin search: first pass from the pointer upward, second pass wraps to 0.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    gnt_oh    = '0;
    gnt_w     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!gnt_found && req[i] && (i >= int'(ptr_q))) begin
        gnt_found = 1'b1;
        gnt_idx   = PTR_W'(i);
        gnt_oh[i] = 1'b1;
        gnt_w     = weight[i*W +: W];
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!gnt_found && req[i]) begin
        gnt_found = 1'b1;
        gnt_idx   = PTR_W'(i);
        gnt_oh[i] = 1'b1;
        gnt_w     = weight[i*W +: W];
      end
    end
  end

`ifdef SYNAPSE_REFRACTORY_EN
  assign grant_en = (state_q == S_ACCUM) || (state_q == S_REFRAC);
`else
  assign grant_en = (state_q == S_ACCUM);
`endif
  assign gnt = grant_en && gnt_found;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic; a falling enable only takes effect at timestep boundaries.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (enable) state_d = S_ACCUM;
      S_ACCUM: if (tick_q == TICK_LAST) state_d = S_ISSUE;
      S_ISSUE: begin
`ifdef SYNAPSE_REFRACTORY_EN
        if (spike_pend_q) state_d = S_REFRAC;
        else              state_d = enable ? S_ACCUM : S_IDLE;
`else
        state_d = enable ? S_ACCUM : S_IDLE;
`endif
      end
`ifdef SYNAPSE_REFRACTORY_EN
      S_REFRAC: if (refrac_q == REFRAC_LAST) state_d = enable ? S_ACCUM : S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: grant only while arbitrating, valid pulse in ISSUE, busy outside IDLE.
  always_comb begin
    ack         = gnt ? gnt_oh : '0;
    i_syn_valid = (state_q == S_ISSUE);
    busy        = (state_q != S_IDLE);
  end

  // Datapath next-state: pointer advance, saturating accumulation, I_syn capture.
  always_comb begin
    ptr_d      = ptr_q;
    acc_d      = acc_q;
    sat_pend_d = sat_pend_q;
    tick_d     = tick_q;
    i_syn_d    = i_syn_q;
    sat_flag_d = sat_flag_q;
    sum_sat    = '0;
    if (gnt) ptr_d = (gnt_idx == PTR_LAST) ? '0 : gnt_idx + 1'b1;
    case (state_q)
      S_IDLE: begin
        acc_d      = '0;
        sat_pend_d = 1'b0;
        tick_d     = '0;
      end
      S_ACCUM: begin
        if (gnt) begin
          sum_sat    = sat_add(acc_q, gnt_w);
          acc_d      = sum_sat[W-1:0];
          sat_pend_d = sat_pend_q | sum_sat[W];
        end
        tick_d = tick_q + 8'd1;
        // The last grant of the timestep is folded in before capture.
        if (tick_q == TICK_LAST) begin
          i_syn_d    = acc_d;
          sat_flag_d = sat_pend_d;
        end
      end
      S_ISSUE: begin
        acc_d      = '0;
        sat_pend_d = 1'b0;
        tick_d     = '0;
      end
      default: ;
    endcase
  end

  // Datapath registers; reset discards any partial accumulation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q      <= '0;
      acc_q      <= '0;
      sat_pend_q <= 1'b0;
      tick_q     <= '0;
      i_syn_q    <= '0;
      sat_flag_q <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      acc_q      <= acc_d;
      sat_pend_q <= sat_pend_d;
      tick_q     <= tick_d;
      i_syn_q    <= i_syn_d;
      sat_flag_q <= sat_flag_d;
    end
  end

  assign i_syn    = i_syn_q;
  assign sat_flag = sat_flag_q;

`ifdef SYNAPSE_REFRACTORY_EN
  // Refractory next-state: latch spikes, count REFRAC cycles, count dropped weights.
  always_comb begin
    spike_pend_d = spike_pend_q;
    refrac_d     = refrac_q;
    drop_d       = drop_q;
    if (((state_q == S_ACCUM) || (state_q == S_ISSUE)) && spike_in) spike_pend_d = 1'b1;
    // Entering REFRAC consumes the pending spike, even if another arrives this cycle.
    if ((state_q == S_ISSUE) && (state_d == S_REFRAC)) spike_pend_d = 1'b0;
    if (state_q == S_REFRAC) begin
      refrac_d = (refrac_q == REFRAC_LAST) ? 8'd0 : refrac_q + 8'd1;
      if (gnt) drop_d = sat_inc8(drop_q);
    end
  end

  // Refractory registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spike_pend_q <= 1'b0;
      refrac_q     <= '0;
      drop_q       <= '0;
    end else begin
      spike_pend_q <= spike_pend_d;
      refrac_q     <= refrac_d;
      drop_q       <= drop_d;
    end
  end

  assign drop_cnt = drop_q;
`else
  localparam int unused_refrac_len = REFRAC_LEN;
  logic unused_spike;
  assign unused_spike = spike_in;
  assign drop_cnt     = '0;
`endif

endmodule
